// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between the fetch port (imem) and the
// load/store port (dmem). Each port owns a one-entry request buffer, data wins
// arbitration unless fetch has been starved STARVE_MAX times, and iflush
// cancels fetches that became stale after a redirect.

package mem_arbiter_pkg;
  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        rst,
  input  logic        clk,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  input  logic        iflush,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  state_t     state_q, state_d;
  mem_in_type pend_i_q, pend_i_d;
  mem_in_type pend_d_q, pend_d_d;
  mem_in_type mem_in_q, mem_in_d;
  logic [2:0] starve_q, starve_d;
  logic       kill_q, kill_d;
  logic       overrun_q, overrun_d;

  logic bus_rdy;
  logic i_inflight;
  logic i_done;
  logic d_done;
  logic i_free;
  logic d_free;
  logic issue;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  assign bus_rdy = mem_out.mem_ready;
  // pend_i describes the transaction on the bus only while a fetch is in
  // flight and has not been killed; after a flush it holds the redirect target.
  assign i_inflight = (state_q == BUSY_I) && !kill_q;
  assign i_done     = (state_q == BUSY_I) && bus_rdy;
  assign d_done     = (state_q == BUSY_D) && bus_rdy;
  // A buffer accepts a new request when empty or emptying this cycle.
  assign i_free     = !pend_i_q.mem_valid || iflush || (i_inflight && bus_rdy);
  assign d_free     = !pend_d_q.mem_valid || d_done;
  // A new grant may be made from IDLE or in the completing cycle of a transfer.
  assign issue      = (state_q == IDLE) || bus_rdy;

  // Next-state: buffer capture/free, flush handling, arbitration and bus load.
  always_comb begin
    state_d   = state_q;
    pend_i_d  = pend_i_q;
    pend_d_d  = pend_d_q;
    mem_in_d  = mem_in_q;
    starve_d  = starve_q;
    kill_d    = kill_q;
    overrun_d = overrun_q;

    if (iflush || (i_inflight && bus_rdy)) pend_i_d.mem_valid = 1'b0;
    if (d_done) pend_d_d.mem_valid = 1'b0;

    if (imem_in.mem_valid) begin
      if (i_free) begin
        pend_i_d           = imem_in;
        pend_i_d.mem_valid = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (dmem_in.mem_valid) begin
      if (d_free) begin
        pend_d_d           = dmem_in;
        pend_d_d.mem_valid = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    // The kill flag lives only as long as the in-flight fetch it suppresses.
    if ((state_q == BUSY_I) && !bus_rdy) kill_d = kill_q || iflush;
    else                                 kill_d = 1'b0;

    if (issue) begin
      if (pend_d_d.mem_valid && !(pend_i_d.mem_valid && (starve_q == STARVE_LIM))) begin
        state_d  = BUSY_D;
        mem_in_d = pend_d_d;
        starve_d = pend_i_d.mem_valid ? sat_inc3(starve_q) : 3'd0;
      end else if (pend_i_d.mem_valid) begin
        state_d            = BUSY_I;
        mem_in_d           = pend_i_d;
        mem_in_d.mem_instr = 1'b1;
        starve_d           = 3'd0;
      end else begin
        state_d  = IDLE;
        mem_in_d = '0;
        starve_d = 3'd0;
      end
    end else if (!pend_i_d.mem_valid) begin
      starve_d = 3'd0;
    end
  end

  // Port responses are combinational from the bus; rdata is zeroed when not ready.
  always_comb begin
    imem_out = '0;
    dmem_out = '0;
    if (i_done && !kill_q && !iflush) begin
      imem_out.mem_ready = 1'b1;
      imem_out.mem_rdata = mem_out.mem_rdata;
    end
    if (d_done) begin
      dmem_out.mem_ready = 1'b1;
      dmem_out.mem_rdata = mem_out.mem_rdata;
    end
  end

  assign mem_in  = mem_in_q;
  assign overrun = overrun_q;

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      pend_i_q  <= '0;
      pend_d_q  <= '0;
      mem_in_q  <= '0;
      starve_q  <= 3'd0;
      kill_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_i_q  <= pend_i_d;
      pend_d_q  <= pend_d_d;
      mem_in_q  <= mem_in_d;
      starve_q  <= starve_d;
      kill_q    <= kill_d;
      overrun_q <= overrun_d;
    end
  end

endmodule
